// File: rtl/ahblite_busmatrix_outputstage_nport.sv
// AHB-Lite bus-matrix output stage for NUM_PORTS masters sharing one slave.
// Arbitrates the address phase, locks bursts and muxes the write-data phase.
module ahblite_busmatrix_outputstage_nport #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int BURST_LOCK = 1
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic [NUM_PORTS-1:0]            HSEL_IN,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] HADDR_IN,
    input  logic [2*NUM_PORTS-1:0]          HTRANS_IN,
    input  logic [NUM_PORTS-1:0]            HWRITE_IN,
    input  logic [3*NUM_PORTS-1:0]          HSIZE_IN,
    input  logic [3*NUM_PORTS-1:0]          HBURST_IN,
    input  logic [4*NUM_PORTS-1:0]          HPROT_IN,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] HWDATA_IN,
    input  logic [NUM_PORTS-1:0]            TRANS_HOLD_IN,
    input  logic                            HREADYOUT,
    output logic [NUM_PORTS-1:0]            ACTIVE,
    output logic                            HSEL,
    output logic [ADDR_WIDTH-1:0]           HADDR,
    output logic [1:0]                      HTRANS,
    output logic                            HWRITE,
    output logic [2:0]                      HSIZE,
    output logic [2:0]                      HBURST,
    output logic [3:0]                      HPROT,
    output logic                            HREADY,
    output logic [DATA_WIDTH-1:0]           HWDATA
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_INCR   = 3'b001;
    localparam logic [2:0] BU_WRAP4  = 3'b010;
    localparam logic [2:0] BU_INCR4  = 3'b011;
    localparam logic [2:0] BU_WRAP8  = 3'b100;
    localparam logic [2:0] BU_INCR8  = 3'b101;
    localparam logic [2:0] BU_WRAP16 = 3'b110;
    localparam logic [2:0] BU_INCR16 = 3'b111;

    logic [NUM_PORTS-1:0] req;
    logic                 addr_valid;
    logic [IW-1:0]        addr_owner;
    logic                 data_valid;
    logic [IW-1:0]        data_owner;
    logic [IW-1:0]        rr_ptr;
    logic [3:0]           beat_cnt;
    logic                 lock;

    logic                 owner_req;
    logic                 lock_nxt;
    logic [3:0]           cnt_nxt;
    logic                 fp_hit;
    logic [IW-1:0]        fp_win;
    logic                 rr_hit;
    logic [IW-1:0]        rr_win;
    logic [IW:0]          rr_sum;
    logic                 arb_hit;
    logic [IW-1:0]        arb_win;

    assign req = TRANS_HOLD_IN & HSEL_IN;

    // Address/control mux from the current address-phase owner
    always_comb begin
        ACTIVE    = '0;
        HSEL      = 1'b0;
        HADDR     = '0;
        HTRANS    = TR_IDLE;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HBURST    = '0;
        HPROT     = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_valid && addr_owner == IW'(i)) begin
                ACTIVE[i] = 1'b1;
                HSEL      = HSEL_IN[i];
                HADDR     = HADDR_IN[i*ADDR_WIDTH +: ADDR_WIDTH];
                HTRANS    = HTRANS_IN[i*2 +: 2];
                HWRITE    = HWRITE_IN[i];
                HSIZE     = HSIZE_IN[i*3 +: 3];
                HBURST    = HBURST_IN[i*3 +: 3];
                HPROT     = HPROT_IN[i*4 +: 4];
                owner_req = req[i];
            end
        end
    end

    // Write-data mux from the data-phase owner
    always_comb begin
        HWDATA = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_valid && data_owner == IW'(i)) begin
                HWDATA = HWDATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign HREADY = data_valid ? HREADYOUT : 1'b1;

    // Fixed priority: scan downwards so the lowest requester is kept
    always_comb begin
        fp_hit = 1'b0;
        fp_win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                fp_hit = 1'b1;
                fp_win = IW'(i);
            end
        end
    end

    // Round-robin: nearest requester after rr_ptr wins
    always_comb begin
        rr_hit = 1'b0;
        rr_win = '0;
        rr_sum = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(NUM_PORTS)) begin
                rr_sum = rr_sum - (IW+1)'(NUM_PORTS);
            end
            if (req[rr_sum[IW-1:0]]) begin
                rr_hit = 1'b1;
                rr_win = rr_sum[IW-1:0];
            end
        end
    end

    assign arb_hit = (ARB_MODE != 0) ? rr_hit : fp_hit;
    assign arb_win = (ARB_MODE != 0) ? rr_win : fp_win;

    // Burst lock: decided from the owner transfer seen on this edge
    always_comb begin
        lock_nxt = lock;
        cnt_nxt  = beat_cnt;
        if (BURST_LOCK != 0 && addr_valid) begin
            if (!lock) begin
                if (HSEL && HTRANS == TR_NONSEQ) begin
                    unique case (HBURST)
                        BU_INCR4, BU_WRAP4: begin
                            lock_nxt = 1'b1;
                            cnt_nxt  = 4'd3;
                        end
                        BU_INCR8, BU_WRAP8: begin
                            lock_nxt = 1'b1;
                            cnt_nxt  = 4'd7;
                        end
                        BU_INCR16, BU_WRAP16: begin
                            lock_nxt = 1'b1;
                            cnt_nxt  = 4'd15;
                        end
                        BU_INCR: begin
                            lock_nxt = 1'b1;
                            cnt_nxt  = 4'd0;
                        end
                        default: begin
                            lock_nxt = 1'b0;
                            cnt_nxt  = 4'd0;
                        end
                    endcase
                end
            end else if (!owner_req) begin
                lock_nxt = 1'b0;
                cnt_nxt  = 4'd0;
            end else if (beat_cnt != 4'd0) begin
                // fixed-length burst: count SEQ beats, BUSY just waits
                if (HTRANS == TR_SEQ) begin
                    cnt_nxt = beat_cnt - 4'd1;
                    if (beat_cnt == 4'd1) begin
                        lock_nxt = 1'b0;
                    end
                end else if (HTRANS != TR_BUSY) begin
                    lock_nxt = 1'b0;
                    cnt_nxt  = 4'd0;
                end
            end else begin
                // undefined-length burst ends on IDLE or a fresh NONSEQ
                if (HTRANS == TR_IDLE || HTRANS == TR_NONSEQ) begin
                    lock_nxt = 1'b0;
                end
            end
        end
    end

    // State update; a stalled slave (HREADY=0) freezes everything
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_valid <= 1'b0;
            addr_owner <= '0;
            data_valid <= 1'b0;
            data_owner <= '0;
            rr_ptr     <= IW'(NUM_PORTS - 1);
            beat_cnt   <= 4'd0;
            lock       <= 1'b0;
        end else if (HREADY) begin
            lock       <= lock_nxt;
            beat_cnt   <= cnt_nxt;
            data_valid <= HSEL & HTRANS[1];
            data_owner <= addr_owner;
            if (!lock_nxt) begin
                if (arb_hit) begin
                    addr_valid <= 1'b1;
                    addr_owner <= arb_win;
                    rr_ptr     <= arb_win;
                end else begin
                    addr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage_nport.sv
// Directed bench for the N-port output stage: fixed priority and
// round-robin instances share stimulus, expectations are hand-computed.
module tb_ahblite_busmatrix_outputstage_nport;

    localparam int N = 3;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA000_0100;
    localparam logic [31:0] A2 = 32'hA000_0200;
    localparam logic [31:0] D0 = 32'hD000_0000;
    localparam logic [31:0] D1 = 32'hD000_0001;
    localparam logic [31:0] D2 = 32'hD000_0002;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  hsel_in;
    logic [N*32-1:0] haddr_in;
    logic [2*N-1:0] htrans_in;
    logic [N-1:0]  hwrite_in;
    logic [3*N-1:0] hsize_in;
    logic [3*N-1:0] hburst_in;
    logic [4*N-1:0] hprot_in;
    logic [N*32-1:0] hwdata_in;
    logic [N-1:0]  hold_in;
    logic          hreadyout;

    logic [N-1:0]  act_f, act_r;
    logic          hsel_f, hsel_r;
    logic [31:0]   haddr_f, haddr_r;
    logic [1:0]    htrans_f, htrans_r;
    logic          hwrite_f, hwrite_r;
    logic [2:0]    hsize_f, hsize_r;
    logic [2:0]    hburst_f, hburst_r;
    logic [3:0]    hprot_f, hprot_r;
    logic          hready_f, hready_r;
    logic [31:0]   hwdata_f, hwdata_r;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ahblite_busmatrix_outputstage_nport #(
        .NUM_PORTS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ARB_MODE(0), .BURST_LOCK(1)
    ) u_fp (
        .HCLK(clk), .HRESET(rst),
        .HSEL_IN(hsel_in), .HADDR_IN(haddr_in),
        .HTRANS_IN(htrans_in), .HWRITE_IN(hwrite_in),
        .HSIZE_IN(hsize_in), .HBURST_IN(hburst_in),
        .HPROT_IN(hprot_in), .HWDATA_IN(hwdata_in),
        .TRANS_HOLD_IN(hold_in), .HREADYOUT(hreadyout),
        .ACTIVE(act_f), .HSEL(hsel_f), .HADDR(haddr_f),
        .HTRANS(htrans_f), .HWRITE(hwrite_f), .HSIZE(hsize_f),
        .HBURST(hburst_f), .HPROT(hprot_f), .HREADY(hready_f),
        .HWDATA(hwdata_f)
    );

    ahblite_busmatrix_outputstage_nport #(
        .NUM_PORTS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ARB_MODE(1), .BURST_LOCK(1)
    ) u_rr (
        .HCLK(clk), .HRESET(rst),
        .HSEL_IN(hsel_in), .HADDR_IN(haddr_in),
        .HTRANS_IN(htrans_in), .HWRITE_IN(hwrite_in),
        .HSIZE_IN(hsize_in), .HBURST_IN(hburst_in),
        .HPROT_IN(hprot_in), .HWDATA_IN(hwdata_in),
        .TRANS_HOLD_IN(hold_in), .HREADYOUT(hreadyout),
        .ACTIVE(act_r), .HSEL(hsel_r), .HADDR(haddr_r),
        .HTRANS(htrans_r), .HWRITE(hwrite_r), .HSIZE(hsize_r),
        .HBURST(hburst_r), .HPROT(hprot_r), .HREADY(hready_r),
        .HWDATA(hwdata_r)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic sel, input logic hold,
                         input logic [1:0] tr, input logic [2:0] bu,
                         input logic [31:0] addr);
        hsel_in[i]          = sel;
        hold_in[i]          = hold;
        htrans_in[i*2 +: 2] = tr;
        hburst_in[i*3 +: 3] = bu;
        haddr_in[i*32 +: 32] = addr;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, IDLE, SINGLE, 32'h0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle_all();
        hreadyout = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hreadyout = 1'b1;
        for (int i = 0; i < N; i++) begin
            hwrite_in[i]           = 1'b1;
            hsize_in[i*3 +: 3]     = 3'b010;
            hprot_in[i*4 +: 4]     = 4'(i + 1);
            hwdata_in[i*32 +: 32]  = 32'hD000_0000 + 32'(i);
        end
        idle_all();

        // reset state
        reset_dut();
        check("rst_active", act_f, 0);
        check("rst_hsel", hsel_f, 0);
        check("rst_htrans", htrans_f, 0);
        check("rst_haddr", haddr_f, 0);
        check("rst_hready", hready_f, 1);
        check("rst_hwdata", hwdata_f, 0);

        // fixed priority: REQ 110 then 111
        set_m(1, 1'b1, 1'b1, NONSEQ, SINGLE, A1);
        set_m(2, 1'b1, 1'b1, NONSEQ, SINGLE, A2);
        #1;
        check("fp_pre_active", act_f, 0);
        tick();
        check("fp_act_110", act_f, 3'b010);
        check("fp_haddr_1", haddr_f, A1);
        check("fp_htrans_1", htrans_f, NONSEQ);
        check("fp_hwrite_1", hwrite_f, 1);
        check("fp_hprot_1", hprot_f, 4'd2);
        check("fp_hsize_1", hsize_f, 3'b010);
        check("fp_hwdata_none", hwdata_f, 0);
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        tick();
        check("fp_act_111", act_f, 3'b001);
        check("fp_haddr_0", haddr_f, A0);
        check("fp_hwdata_1", hwdata_f, D1);
        tick();
        check("fp_act_hold0", act_f, 3'b001);
        check("fp_hwdata_0", hwdata_f, D0);
        idle_all();
        tick();
        check("fp_act_none", act_f, 0);
        check("fp_hwdata_idle", hwdata_f, 0);

        // round-robin rotation
        reset_dut();
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        set_m(1, 1'b1, 1'b1, NONSEQ, SINGLE, A1);
        set_m(2, 1'b1, 1'b1, NONSEQ, SINGLE, A2);
        tick();
        check("rr_act_1", act_r, 3'b001);
        tick();
        check("rr_act_2", act_r, 3'b010);
        check("rr_haddr_2", haddr_r, A1);
        tick();
        check("rr_act_3", act_r, 3'b100);
        check("rr_hwdata_3", hwdata_r, D1);
        check("fp_act_steady", act_f, 3'b001);
        tick();
        check("rr_act_4", act_r, 3'b001);

        // INCR4 from master 1 with master 0 waiting
        reset_dut();
        set_m(1, 1'b1, 1'b1, NONSEQ, INCR4, 32'h1000);
        tick();
        check("b4_grant", act_f, 3'b010);
        check("b4_hburst", hburst_f, INCR4);
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        tick();
        check("b4_nonseq", act_f, 3'b010);
        set_m(1, 1'b1, 1'b1, SEQ, INCR4, 32'h1004);
        tick();
        check("b4_seq1", act_f, 3'b010);
        check("b4_hwdata", hwdata_f, D1);
        set_m(1, 1'b1, 1'b1, SEQ, INCR4, 32'h1008);
        tick();
        check("b4_seq2", act_f, 3'b010);
        check("b4_haddr", haddr_f, 32'h1008);
        set_m(1, 1'b1, 1'b1, SEQ, INCR4, 32'h100C);
        tick();
        check("b4_handover", act_f, 3'b001);

        // slave wait states during master 2 data phase
        reset_dut();
        set_m(2, 1'b1, 1'b1, NONSEQ, SINGLE, A2);
        tick();
        check("ws_grant", act_f, 3'b100);
        tick();
        check("ws_dphase", hwdata_f, D2);
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        hreadyout = 1'b0;
        #1;
        check("ws_hready_comb", hready_f, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("ws_act", act_f, 3'b100);
            check("ws_haddr", haddr_f, A2);
            check("ws_hwdata", hwdata_f, D2);
            check("ws_hready", hready_f, 0);
        end
        hreadyout = 1'b1;
        #1;
        check("ws_hready_back", hready_f, 1);
        tick();
        check("ws_regrant", act_f, 3'b001);

        // INCR with BUSY keeps the lock; IDLE releases it
        reset_dut();
        set_m(1, 1'b1, 1'b1, NONSEQ, INCR, 32'h2000);
        tick();
        check("inc_grant", act_f, 3'b010);
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        tick();
        check("inc_nonseq", act_f, 3'b010);
        set_m(1, 1'b1, 1'b1, BUSY, INCR, 32'h2004);
        #1;
        check("inc_htrans_busy", htrans_f, BUSY);
        tick();
        check("inc_busy1", act_f, 3'b010);
        check("inc_busy_nodata", hwdata_f, 0);
        set_m(1, 1'b1, 1'b1, SEQ, INCR, 32'h2004);
        tick();
        check("inc_seq", act_f, 3'b010);
        set_m(1, 1'b1, 1'b1, BUSY, INCR, 32'h2008);
        tick();
        check("inc_busy2", act_f, 3'b010);
        set_m(1, 1'b1, 1'b1, IDLE, INCR, 32'h2008);
        tick();
        check("inc_release", act_f, 3'b001);

        // reset in the middle of an INCR8
        reset_dut();
        set_m(2, 1'b1, 1'b1, NONSEQ, INCR8, 32'h3000);
        tick();
        check("r8_grant", act_f, 3'b100);
        set_m(0, 1'b1, 1'b1, NONSEQ, SINGLE, A0);
        tick();
        check("r8_beat1", act_f, 3'b100);
        set_m(2, 1'b1, 1'b1, SEQ, INCR8, 32'h3004);
        tick();
        check("r8_beat2", act_f, 3'b100);
        set_m(2, 1'b1, 1'b1, SEQ, INCR8, 32'h3008);
        rst = 1'b1;
        tick();
        check("r8_rst_active", act_f, 0);
        check("r8_rst_htrans", htrans_f, 0);
        check("r8_rst_hready", hready_f, 1);
        check("r8_rst_hwdata", hwdata_f, 0);
        check("r8_rst_active_rr", act_r, 0);
        rst = 1'b0;
        tick();
        check("r8_fresh_fp", act_f, 3'b001);
        check("r8_fresh_rr", act_r, 3'b001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ahblite_busmatrix_outputstage_nport.md
# ahblite_busmatrix_outputstage_nport

Parametrised AHB-Lite bus-matrix output stage. It arbitrates between NUM_PORTS input-stage masters for one slave port and muxes the address/control phase and the write-data phase onto that slave. It supports fixed-priority or round-robin arbitration and keeps the grant locked for the whole of a fixed-length or INCR burst. It is the generalised replacement for the two-master (SYS/DMA) output stages in the bus matrix.

## Interface
- NUM_PORTS, 3 — number of masters, 2..8
- ADDR_WIDTH, 32 — HADDR width
- DATA_WIDTH, 32 — HWDATA width
- ARB_MODE, 0 — 0: fixed priority (lowest index wins); 1: round-robin
- BURST_LOCK, 1 — 1: grant held for the whole burst; 0: re-arbitrate on every accepted transfer

Ports (input i uses slice [i*W +: W]):
- HCLK  input  1  clock; all state on rising edge
- HRESET  input  1  reset, synchronous, active-high
- HSEL_IN  input  NUM_PORTS  per-master slave select
- HADDR_IN  input  NUM_PORTS*ADDR_WIDTH  per-master address
- HTRANS_IN  input  2*NUM_PORTS  per-master transfer type
- HWRITE_IN  input  NUM_PORTS  per-master write flag
- HSIZE_IN  input  3*NUM_PORTS  per-master size
- HBURST_IN  input  3*NUM_PORTS  per-master burst type
- HPROT_IN  input  4*NUM_PORTS  per-master protection
- HWDATA_IN  input  NUM_PORTS*DATA_WIDTH  per-master write data
- TRANS_HOLD_IN  input  NUM_PORTS  input stage holds a pending transfer
- HREADYOUT  input  1  slave ready
- ACTIVE  output  NUM_PORTS  one-hot: master i owns the address phase
- HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  output  1/ADDR_WIDTH/2/1/3/3/4  muxed address phase
- HREADY  output  1  ready to slave and input stages
- HWDATA  output  DATA_WIDTH  muxed write data

## Operation
- REQ[i] = TRANS_HOLD_IN[i] & HSEL_IN[i].
- Registers:
  - addr_valid, addr_owner: address-phase grant.
  - data_valid, data_owner: data-phase owner.
  - rr_ptr: last granted index.
  - beat_cnt: 4 bits.
  - lock: 1 bit.
- Arbitration is evaluated only on edges where HREADY=1 and lock=0. If no REQ, addr_valid←0.
  - Fixed priority: the lowest-index requester wins.
  - Round-robin: search from rr_ptr+1 modulo NUM_PORTS. rr_ptr←winner on each new grant.
- Address mux: when addr_valid=0, all address/control outputs are 0 (HTRANS=IDLE). Otherwise they carry master addr_owner's signals. ACTIVE = addr_valid ? onehot(addr_owner) : 0.
- Burst lock (BURST_LOCK=1), applied to the accepted owner transfer on an HREADY=1 edge:
  - NONSEQ with INCR4/WRAP4: lock←1, beat_cnt←3.
  - NONSEQ with INCR8/WRAP8: lock←1, beat_cnt←7.
  - NONSEQ with INCR16/WRAP16: lock←1, beat_cnt←15.
  - Accepted SEQ in a fixed burst: beat_cnt−1; lock←0 when it reaches 0.
  - NONSEQ INCR: lock←1. Lock is held while the owner presents SEQ or BUSY, and released on an owner edge showing IDLE/NONSEQ, or when REQ[owner]=0.
  - SINGLE: no lock.
  - BURST_LOCK=0: lock stays 0.
- Data phase: on HREADY=1, data_valid←HSEL & HTRANS[1], and data_owner←addr_owner. Both hold while HREADY=0.
- HREADY = data_valid ? HREADYOUT : 1.
- HWDATA = data_valid ? HWDATA_IN[data_owner] : 0.
- Grant changes never occur while HREADY=0; a stalled slave freezes every register.
- Reset values:
  - addr_valid=0, data_valid=0, lock=0, beat_cnt=0, rr_ptr=NUM_PORTS−1, owners=0.
  - Outputs: ACTIVE=0, HSEL=0, HTRANS=0, all buses 0, HREADY=1, HWDATA=0.
- Reset asserted mid-burst: all state is cleared on that edge. The burst is abandoned and there is no residual lock.

## Timing
- Grant latency is 1 cycle. REQ sampled at edge t with HREADY=1 → outputs and ACTIVE switch after edge t.
- The data phase follows the address phase by exactly one HREADY=1 edge.
- HREADY is combinational from HREADYOUT during a data phase (zero added latency).
- Simultaneous requests resolve in the same edge. A new grant and a data-phase handover of the previous owner can share one edge (pipelined overlap).
- Back-to-back fixed bursts from different masters have no idle cycle between the last SEQ and the next NONSEQ.

## Test plan
- Fixed priority, NUM_PORTS=3: REQ=3'b110 then 3'b111 → ACTIVE=3'b010, then 3'b001 after the next HREADY edge. HWDATA follows one cycle later.
- Round-robin: all three request continuously with SINGLE transfers → ACTIVE sequence 001,010,100,001…, one grant per cycle.
- Burst lock: master 1 issues INCR4 while master 0 requests → ACTIVE stays 010 for NONSEQ+3 SEQ. Master 0 is granted on the edge accepting the 4th beat.
- Slave wait states: HREADYOUT=0 for 3 cycles during master 2's data phase → HREADY=0. Owner, HADDR and HWDATA are frozen; the grant is unchanged.
- INCR with BUSY: an undefined-length burst with interleaved BUSY cycles keeps the lock. Owner IDLE → lock releases and a competing master is granted the next cycle.
- Reset mid-burst: HRESET=1 during INCR8 beat 3 → the next cycle shows ACTIVE=0, HTRANS=0, HREADY=1, and the lock is cleared. After release, fresh arbitration starts at port 0.
